// File: rtl/m_issue_ctrl_pkg.sv
// Shared core definitions: instruction kinds, register-file sizing and a
// one-hot helper used by the scoreboard masks.
package p_core;

    localparam int REG_COUNT = 32;
    localparam int REG_SEL_W = 5;

    typedef enum logic [2:0] {
        KIND_ALU     = 3'd0,
        KIND_ALU_IMM = 3'd1,
        KIND_LOAD    = 3'd2,
        KIND_STORE   = 3'd3,
        KIND_BRANCH  = 3'd4,
        KIND_JUMP    = 3'd5,
        KIND_SYSTEM  = 3'd6,
        KIND_ILLEGAL = 3'd7
    } e_kind;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_SEL_W-1:0] idx);
        logic [REG_COUNT-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/m_issue_ctrl_if.sv
// Decode/issue/writeback bundle between the front end, the issue controller
// and execute. The master side is the decoder plus execute; the slave side is
// the issue controller.
interface m_issue_ctrl_if;
    import p_core::*;

    logic                 dec_valid;
    logic                 dec_ready;
    logic [31:0]          dec_instruction;
    e_kind                dec_kind;
    logic [REG_SEL_W-1:0] dec_rs_sel;
    logic [REG_SEL_W-1:0] dec_rq_sel;
    logic [REG_SEL_W-1:0] dec_rd;
    logic                 dec_uses_rs;
    logic                 dec_uses_rq;
    logic                 dec_writes_rd;

    logic                 iss_valid;
    logic                 iss_ready;
    logic [31:0]          iss_instruction;
    e_kind                iss_kind;
    logic [REG_SEL_W-1:0] iss_rs_sel;
    logic [REG_SEL_W-1:0] iss_rq_sel;
    logic [REG_SEL_W-1:0] iss_rd;

    logic                 wb_valid;
    logic [REG_SEL_W-1:0] wb_rd;
    logic                 flush;

    modport master (
        output dec_valid, dec_instruction, dec_kind, dec_rs_sel, dec_rq_sel, dec_rd,
               dec_uses_rs, dec_uses_rq, dec_writes_rd, iss_ready, wb_valid, wb_rd, flush,
        input  dec_ready, iss_valid, iss_instruction, iss_kind, iss_rs_sel, iss_rq_sel, iss_rd
    );

    modport slave (
        input  dec_valid, dec_instruction, dec_kind, dec_rs_sel, dec_rq_sel, dec_rd,
               dec_uses_rs, dec_uses_rq, dec_writes_rd, iss_ready, wb_valid, wb_rd, flush,
        output dec_ready, iss_valid, iss_instruction, iss_kind, iss_rs_sel, iss_rq_sel, iss_rd
    );

endinterface

// File: rtl/m_issue_ctrl_scoreboard.sv
// Register busy scoreboard. Lookups see the writeback bypass so a reader can
// issue in the same cycle its producer writes back; a set beats any clear.
module m_scoreboard
    import p_core::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_SEL_W-1:0] set_idx,
    input  logic                 wb_en,
    input  logic [REG_SEL_W-1:0] wb_idx,
    input  logic                 flush_clr_en,
    input  logic [REG_SEL_W-1:0] flush_clr_idx,
    input  logic [REG_SEL_W-1:0] rs_idx,
    input  logic [REG_SEL_W-1:0] rq_idx,
    input  logic [REG_SEL_W-1:0] rd_idx,
    output logic                 rs_busy,
    output logic                 rq_busy,
    output logic                 rd_busy,
    output logic [REG_COUNT-1:0] busy
);
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_COUNT-1:0] wb_mask, set_mask, flush_mask, busy_eff;

    // Build masks, bypassed lookup view and the next scoreboard value; x0 stays clear.
    always_comb begin
        wb_mask    = wb_en        ? reg_onehot(wb_idx)        : '0;
        set_mask   = set_en       ? reg_onehot(set_idx)       : '0;
        flush_mask = flush_clr_en ? reg_onehot(flush_clr_idx) : '0;
        busy_eff   = busy_q & ~wb_mask;
        rs_busy    = busy_eff[rs_idx];
        rq_busy    = busy_eff[rq_idx];
        rd_busy    = busy_eff[rd_idx];
        busy_d     = (busy_q & ~wb_mask & ~flush_mask) | set_mask;
        busy_d[0]  = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/m_issue_ctrl.sv
// Issue controller: stalls decode on RAW/WAW hazards against the scoreboard,
// holds one decoded instruction for execute, handles flush and counts stalls.
module m_issue_ctrl
    import p_core::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    m_issue_ctrl_if.slave          bus,
    output logic [REG_COUNT-1:0]   busy,
    output logic [STALL_CNT_W-1:0] stall_count
);
    logic                   rs_busy, rq_busy, rd_busy;
    logic                   hazard, slot_free, dec_ready, accept, set_en, flush_clr;
    logic                   iss_valid_q, iss_valid_d;
    logic                   iss_wr_q, iss_wr_d;
    logic [31:0]            iss_instr_q, iss_instr_d;
    e_kind                  iss_kind_q, iss_kind_d;
    logic [REG_SEL_W-1:0]   iss_rs_q, iss_rs_d;
    logic [REG_SEL_W-1:0]   iss_rq_q, iss_rq_d;
    logic [REG_SEL_W-1:0]   iss_rd_q, iss_rd_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    m_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (set_en),
        .set_idx       (bus.dec_rd),
        .wb_en         (bus.wb_valid),
        .wb_idx        (bus.wb_rd),
        .flush_clr_en  (flush_clr),
        .flush_clr_idx (iss_rd_q),
        .rs_idx        (bus.dec_rs_sel),
        .rq_idx        (bus.dec_rq_sel),
        .rd_idx        (bus.dec_rd),
        .rs_busy       (rs_busy),
        .rq_busy       (rq_busy),
        .rd_busy       (rd_busy),
        .busy          (busy)
    );

    // Hazard detection and the decode handshake; a flush only releases the
    // held destination when execute is not taking the instruction this cycle.
    always_comb begin
        hazard    = (bus.dec_uses_rs && rs_busy) ||
                    (bus.dec_uses_rq && rq_busy) ||
                    (bus.dec_writes_rd && rd_busy);
        slot_free = !iss_valid_q || bus.iss_ready;
        dec_ready = slot_free && !hazard && !bus.flush;
        accept    = bus.dec_valid && dec_ready;
        set_en    = accept && bus.dec_writes_rd && (bus.dec_rd != '0);
        flush_clr = bus.flush && iss_valid_q && !bus.iss_ready && iss_wr_q && (iss_rd_q != '0);
    end

    // Next state of the issue register: load on accept, drain on handoff or flush.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_wr_d    = iss_wr_q;
        iss_instr_d = iss_instr_q;
        iss_kind_d  = iss_kind_q;
        iss_rs_d    = iss_rs_q;
        iss_rq_d    = iss_rq_q;
        iss_rd_d    = iss_rd_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_wr_d    = bus.dec_writes_rd;
            iss_instr_d = bus.dec_instruction;
            iss_kind_d  = bus.dec_kind;
            iss_rs_d    = bus.dec_rs_sel;
            iss_rq_d    = bus.dec_rq_sel;
            iss_rd_d    = bus.dec_rd;
        end else if (bus.flush || (iss_valid_q && bus.iss_ready)) begin
            iss_valid_d = 1'b0;
        end
    end

    // Saturating count of cycles where decode offers an instruction but is held off.
    always_comb begin
        stall_d = stall_q;
        if (bus.dec_valid && !dec_ready && (stall_q != '1)) begin
            stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Issue register and stall counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_wr_q    <= 1'b0;
            iss_instr_q <= '0;
            iss_kind_q  <= KIND_ALU;
            iss_rs_q    <= '0;
            iss_rq_q    <= '0;
            iss_rd_q    <= '0;
            stall_q     <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_wr_q    <= iss_wr_d;
            iss_instr_q <= iss_instr_d;
            iss_kind_q  <= iss_kind_d;
            iss_rs_q    <= iss_rs_d;
            iss_rq_q    <= iss_rq_d;
            iss_rd_q    <= iss_rd_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.dec_ready       = dec_ready;
    assign bus.iss_valid       = iss_valid_q;
    assign bus.iss_instruction = iss_instr_q;
    assign bus.iss_kind        = iss_kind_q;
    assign bus.iss_rs_sel      = iss_rs_q;
    assign bus.iss_rq_sel      = iss_rq_q;
    assign bus.iss_rd          = iss_rd_q;
    assign stall_count         = stall_q;

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Directed bench for the issue controller: a register-level model of the
// scoreboard and issue slot is checked every cycle, plus literal expectations.
module tb_m_issue_ctrl;
    import p_core::*;

    localparam int STALL_CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            busy;
    logic [STALL_CNT_W-1:0] stall_count;
    int                     checks = 0;
    int                     errors = 0;
    bit                     chk_en = 1'b0;

    m_issue_ctrl_if bus ();

    m_issue_ctrl #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .stall_count (stall_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        e_kind       kind;
        logic [4:0]  rs;
        logic [4:0]  rq;
        logic [4:0]  rd;
        bit          wr;
    } held_t;

    bit          m_busy [32];
    bit          m_valid = 1'b0;
    held_t       m_held  = '{32'h0, KIND_ALU, 5'd0, 5'd0, 5'd0, 1'b0};
    int unsigned m_stall = 0;

    function automatic bit reg_busy(input logic [4:0] r);
        return m_busy[r] && !(bus.wb_valid && (bus.wb_rd == r));
    endfunction

    function automatic bit model_ready();
        bit hz;
        hz = (bus.dec_uses_rs && reg_busy(bus.dec_rs_sel)) ||
             (bus.dec_uses_rq && reg_busy(bus.dec_rq_sel)) ||
             (bus.dec_writes_rd && reg_busy(bus.dec_rd));
        return (!m_valid || bus.iss_ready) && !hz && !bus.flush;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the inputs presented this cycle.
    always @(posedge clk) begin
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_valid = 1'b0;
            m_held  = '{32'h0, KIND_ALU, 5'd0, 5'd0, 5'd0, 1'b0};
            m_stall = 0;
        end else begin
            if (bus.dec_valid && !rdy && m_stall < (2**STALL_CNT_W - 1)) m_stall++;
            if (bus.wb_valid) m_busy[bus.wb_rd] = 1'b0;
            if (bus.flush && m_valid && !bus.iss_ready && m_held.wr && m_held.rd != 0)
                m_busy[m_held.rd] = 1'b0;
            if (bus.dec_valid && rdy) begin
                m_valid = 1'b1;
                m_held  = '{bus.dec_instruction, bus.dec_kind, bus.dec_rs_sel,
                            bus.dec_rq_sel, bus.dec_rd, bus.dec_writes_rd};
                if (bus.dec_writes_rd && bus.dec_rd != 0) m_busy[bus.dec_rd] = 1'b1;
            end else if (bus.flush || bus.iss_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        logic [31:0] mb;
        if (chk_en) begin
            for (int i = 0; i < 32; i++) mb[i] = m_busy[i];
            checkOutput("busy", busy, mb);
            checkOutput("dec_ready", 32'(bus.dec_ready), 32'(model_ready()));
            checkOutput("iss_valid", 32'(bus.iss_valid), 32'(m_valid));
            checkOutput("stall_count", 32'(stall_count), m_stall);
            checkOutput("iss_instruction", bus.iss_instruction, m_held.instr);
            checkOutput("iss_kind", 32'(bus.iss_kind), 32'(m_held.kind));
            checkOutput("iss_rs_sel", 32'(bus.iss_rs_sel), 32'(m_held.rs));
            checkOutput("iss_rq_sel", 32'(bus.iss_rq_sel), 32'(m_held.rq));
            checkOutput("iss_rd", 32'(bus.iss_rd), 32'(m_held.rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input e_kind kind, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rq,
                                 input bit urs, input bit urq, input bit wr);
        bus.dec_valid       = valid;
        bus.dec_kind        = kind;
        bus.dec_rd          = rd;
        bus.dec_rs_sel      = rs;
        bus.dec_rq_sel      = rq;
        bus.dec_uses_rs     = urs;
        bus.dec_uses_rq     = urq;
        bus.dec_writes_rd   = wr;
        bus.dec_instruction = {7'h00, rq, rs, 3'b000, rd, 7'h33};
    endtask

    task automatic idle();
        applyStimulus(1'b0, KIND_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeback(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        idle();
        bus.iss_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.flush     = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        checkOutput("reset iss_valid", 32'(bus.iss_valid), 32'h0);
        checkOutput("reset busy", busy, 32'h0);
        checkOutput("reset stall_count", 32'(stall_count), 32'h0);
        rst = 1'b0;

        // Three independent adds flow back to back.
        bus.iss_ready = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b1, KIND_ALU, 5'(r), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            tick();
            checkOutput("b2b iss_valid", 32'(bus.iss_valid), 32'h1);
            checkOutput("b2b iss_rd", 32'(bus.iss_rd), r);
        end
        checkOutput("b2b busy", busy, 32'h0000000E);
        idle();
        tick();
        checkOutput("b2b drained", 32'(bus.iss_valid), 32'h0);
        for (int r = 1; r <= 3; r++) writeback(5'(r));
        checkOutput("wb cleared", busy, 32'h0);

        // RAW on x5 stalls three cycles, released by same-cycle writeback.
        applyStimulus(1'b1, KIND_ALU, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, KIND_ALU, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("raw stall ready", 32'(bus.dec_ready), 32'h0);
            tick();
        end
        checkOutput("raw stall_count", 32'(stall_count), 32'd3);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        #1;
        checkOutput("raw bypass ready", 32'(bus.dec_ready), 32'h1);
        tick();
        bus.wb_valid = 1'b0;
        idle();
        checkOutput("raw accepted rd", 32'(bus.iss_rd), 32'd6);
        checkOutput("raw busy", busy, 32'h00000040);
        writeback(5'd6);

        // Execute back-pressure for four cycles holds the slot stable.
        bus.iss_ready = 1'b0;
        applyStimulus(1'b1, KIND_LOAD, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, KIND_ALU, 5'd11, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("hold ready", 32'(bus.dec_ready), 32'h0);
            checkOutput("hold iss_rd", 32'(bus.iss_rd), 32'd10);
            checkOutput("hold iss_kind", 32'(bus.iss_kind), 32'(KIND_LOAD));
            tick();
        end
        bus.iss_ready = 1'b1;
        #1;
        checkOutput("release ready", 32'(bus.dec_ready), 32'h1);
        tick();
        idle();
        checkOutput("release iss_rd", 32'(bus.iss_rd), 32'd11);
        checkOutput("release stall_count", 32'(stall_count), 32'd7);
        tick();
        writeback(5'd10);
        writeback(5'd11);

        // Writes to x0 never mark it busy and never stall readers.
        applyStimulus(1'b1, KIND_ALU, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("x0 busy", busy, 32'h0);
        applyStimulus(1'b1, KIND_ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("x0 reader ready", 32'(bus.dec_ready), 32'h1);
        tick();
        idle();
        tick();

        // Flush with execute stalled releases x7; with execute taking it x7 stays busy.
        bus.iss_ready = 1'b0;
        applyStimulus(1'b1, KIND_ALU, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("flush pre busy", busy, 32'h00000080);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush ready", 32'(bus.dec_ready), 32'h0);
        tick();
        bus.flush = 1'b0;
        checkOutput("flush iss_valid", 32'(bus.iss_valid), 32'h0);
        checkOutput("flush busy", busy, 32'h0);
        applyStimulus(1'b1, KIND_ALU, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        bus.flush     = 1'b1;
        bus.iss_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush+ready iss_valid", 32'(bus.iss_valid), 32'h0);
        checkOutput("flush+ready busy", busy, 32'h00000080);
        writeback(5'd7);

        // Same-cycle accept and writeback of x9: the set wins.
        applyStimulus(1'b1, KIND_ALU, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        tick();
        bus.wb_valid = 1'b0;
        idle();
        checkOutput("set wins busy", busy, 32'h00000200);
        writeback(5'd9);

        // Reset in the middle of a stall returns everything to reset values.
        applyStimulus(1'b1, KIND_STORE, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, KIND_ALU, 5'd13, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("pre-reset stall_count", 32'(stall_count), 32'd9);
        rst = 1'b1;
        tick();
        checkOutput("rst iss_valid", 32'(bus.iss_valid), 32'h0);
        checkOutput("rst busy", busy, 32'h0);
        checkOutput("rst stall_count", 32'(stall_count), 32'h0);
        checkOutput("rst iss_rd", 32'(bus.iss_rd), 32'h0);
        checkOutput("rst iss_instruction", bus.iss_instruction, 32'h0);
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_issue_ctrl.md
# m_issue_ctrl

Issue controller between the decoder (`m_decoder_kind` / `m_decoder_args`) and the execute stage. It holds a 32-entry register scoreboard, stalls decode on RAW/WAW hazards against in-flight writes, and presents one registered, decoded instruction to execute under a valid/ready handshake. Writeback clears scoreboard entries, and a flush discards the held instruction.

## Interface

Parameters:
- `STALL_CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dec_valid`  in  1  decoder holds a valid instruction.
- `dec_ready`  out  1  controller accepts the instruction this cycle.
- `dec_instruction`  in  32  raw instruction word.
- `dec_kind`  in  e_kind  decoded kind.
- `dec_rs_sel`, `dec_rq_sel`  in  5 each  source register indices.
- `dec_rd`  in  5  destination register index.
- `dec_uses_rs`, `dec_uses_rq`, `dec_writes_rd`  in  1 each  operand-usage flags.
- `iss_valid`  out  1  issue register holds an instruction.
- `iss_ready`  in  1  execute accepts this cycle.
- `iss_instruction`  out  32; `iss_kind`  out  e_kind; `iss_rs_sel`, `iss_rq_sel`, `iss_rd`  out  5 each: registered copies.
- `wb_valid`  in  1; `wb_rd`  in  5: writeback completes and clears the busy bit.
- `flush`  in  1  discard the held issue instruction.
- `busy`  out  32  scoreboard state (debug).
- `stall_count`  out  STALL_CNT_W  cycles with `dec_valid && !dec_ready`, saturating.

## Operation

- The scoreboard `busy[31:0]` has bit 0 hardwired to 0. It is never set and is readable as 0.
- `wb_mask` = `wb_valid` ? onehot(`wb_rd`) : 0. `busy_eff` = `busy & ~wb_mask`, so a same-cycle writeback bypass is allowed.
- A hazard exists if any of the following holds, evaluated against `busy_eff`:
  - `dec_uses_rs` && `busy_eff[dec_rs_sel]`
  - `dec_uses_rq` && `busy_eff[dec_rq_sel]`
  - `dec_writes_rd` && `busy_eff[dec_rd]` (WAW)
- `slot_free` = `!iss_valid || iss_ready`.
- `dec_ready` = `slot_free && !hazard && !flush`. This is combinational and does not depend on `dec_valid`.
- Accept = `dec_valid && dec_ready`. On accept:
  - The issue registers load the decode fields.
  - `iss_valid` is set to 1.
  - If `dec_writes_rd` and `dec_rd != 0`, `busy[dec_rd]` is set.
- Issue-register update when not accepting:
  - If `iss_valid && iss_ready`, `iss_valid` is cleared.
  - Otherwise the issue register holds, and all `iss_*` outputs stay stable while `iss_valid && !iss_ready`.
- Scoreboard next state = `(busy & ~wb_mask) | set_mask`. If a set and a clear target the same index in the same cycle, the set wins.
- Flush:
  - `iss_valid` is cleared next cycle.
  - If the held instruction had `writes_rd` (latched internally) and `iss_rd != 0`, and it is not being accepted by execute this cycle, its busy bit is cleared.
  - When `flush && iss_ready && iss_valid` occur together, execute accepts the instruction: the busy bit is kept and `iss_valid` is cleared.
- `stall_count` increments when `dec_valid && !dec_ready` and saturates at all-ones.
- Reset values: `busy` = 0, `iss_valid` = 0, all `iss_*` fields = 0, `stall_count` = 0, latched `writes_rd` = 0.

## Timing

- Accept in cycle N gives `iss_valid` = 1 in cycle N+1, so latency is one cycle.
- Back-to-back throughput is one instruction per cycle when `iss_ready` is held high and there are no hazards.
- A dependent instruction (RAW on the just-issued `rd`) stalls until the cycle in which `wb_valid` with that `rd` is asserted, and is accepted in that same cycle.
- `rst` asserted mid-operation aborts everything in the following cycle; in-flight writebacks are then ignored (bits are already 0).
- `flush` and `rst` have effect one edge later; neither depends on `dec_valid`.

## Structure

- Shared package `p_core`: `e_kind`, and constants `REG_COUNT` = 32 and `REG_SEL_W` = 5.
- Sub-module `m_scoreboard`: holds `busy`, with set/clear ports and three combinational lookup ports. `m_issue_ctrl` contains the handshake, the issue register, flush handling and the stall counter.

## Test plan

- Reset, then independent `add x1`, `add x2`, `add x3` with `iss_ready` = 1 -> issued on consecutive cycles; `busy` = 0x0000000E.
- Issue `rd` = x5, then a reader of x5 -> `dec_ready` = 0 and `stall_count` counts 3 until `wb_valid`/`wb_rd` = 5 arrives; the reader is accepted in that same cycle.
- `iss_ready` = 0 for 4 cycles with `dec_valid` high -> all `iss_*` outputs stable and `dec_ready` = 0; release -> the next instruction follows one cycle later.
- Writes to x0 -> `busy[0]` stays 0; a reader of x0 is never stalled.
- Flush the held `rd` = x7 with `iss_ready` = 0 -> `iss_valid` = 0 and `busy[7]` = 0 next cycle; the same case with `iss_ready` = 1 -> `busy[7]` stays 1.
- Same-cycle accept of `rd` = x9 and `wb_rd` = 9 with x9 not busy -> `busy[9]` = 1. Assert `rst` mid-stall -> all outputs return to reset values.
